// File: rtl/cpu_trace_monitor.sv
// Capture block for CPU evaluator output streams: per-channel FIFOs merged
// round-robin onto one ready/valid trace port, with drain-on-halt, counters and watchdog.
module cpu_trace_monitor #(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned TIMEOUT  = 1000000,
   localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         halt,
   input  logic [CHANNELS-1:0]          in_valid,
   input  logic [CHANNELS*DATA_W-1:0]   in_data,
   output logic                         trace_valid,
   input  logic                         trace_ready,
   output logic [CW-1:0]                trace_chan,
   output logic [DATA_W-1:0]            trace_data,
   output logic                         trace_idle,
   output logic [31:0]                  cycle_count,
   output logic [15:0]                  drop_count,
   output logic                         overflow,
   output logic                         done,
   output logic                         timeout
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE, S_TMO} state_t;

   state_t                state_q, state_d;
   logic [DATA_W-1:0]     mem_q [CHANNELS][DEPTH];
   logic [AW:0]           wr_q  [CHANNELS];
   logic [AW:0]           wr_d  [CHANNELS];
   logic [AW:0]           rd_q  [CHANNELS];
   logic [AW:0]           rd_d  [CHANNELS];
   logic [CHANNELS-1:0]   empty, full, push, pop, drop;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_W-1:0]     out_data_q, out_data_d;
   logic [CW-1:0]         out_chan_q, out_chan_d;
   logic [CW-1:0]         rr_q, rr_d;
   logic [31:0]           cnt_q, cnt_d;
   logic [15:0]           drop_q, drop_d;
   logic                  ovf_q, ovf_d;
   logic                  active, load, found;
   logic [CW-1:0]         grant;
   logic [DATA_W-1:0]     head;
   int unsigned           cand;
   logic [3:0]            drop_n;
   logic [16:0]           drop_sum;

   assign active = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign load   = active && (!out_valid_q || trace_ready);

   always_comb begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         empty[c] = (wr_q[c] == rd_q[c]);
         full[c]  = (wr_q[c][AW] != rd_q[c][AW]) && (wr_q[c][AW-1:0] == rd_q[c][AW-1:0]);
      end
   end

   // Round-robin search starting one past the last granted channel.
   always_comb begin
      found = 1'b0;
      grant = rr_q;
      head  = '0;
      cand  = 0;
      for (int unsigned k = 1; k <= CHANNELS; k++) begin
         cand = (32'(rr_q) + k) % CHANNELS;
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (!found && (c == cand) && !empty[c]) begin
               found = 1'b1;
               grant = CW'(c);
               head  = mem_q[c][rd_q[c][AW-1:0]];
            end
         end
      end
   end

   always_comb begin
      drop_n = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         pop[c]  = load && found && (32'(grant) == c);
         push[c] = (state_q == S_RUN) && in_valid[c] && (!full[c] || pop[c]);
         drop[c] = (state_q == S_RUN) && in_valid[c] && full[c] && !pop[c];
         wr_d[c] = wr_q[c] + {{AW{1'b0}}, push[c]};
         rd_d[c] = rd_q[c] + {{AW{1'b0}}, pop[c]};
         drop_n  = drop_n + {3'b000, drop[c]};
      end
      drop_sum = {1'b0, drop_q} + {13'd0, drop_n};
      drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      ovf_d    = ovf_q | (|drop);
      cnt_d    = (active && (cnt_q != '1)) ? cnt_q + 32'd1 : cnt_q;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      rr_d        = rr_q;
      if (load) begin
         out_valid_d = found;
         if (found) begin
            out_data_d = head;
            out_chan_d = grant;
            rr_d       = grant;
         end
      end
   end

   // Halt takes priority over the watchdog when both land on the same edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN: begin
            if (halt)
               state_d = S_DRAIN;
            else if ((TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1)))
               state_d = S_TMO;
         end
         S_DRAIN: begin
            if ((&empty) && (!out_valid_q || trace_ready))
               state_d = S_DONE;
         end
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_RUN;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         rr_q        <= CW'(CHANNELS - 1);
         cnt_q       <= '0;
         drop_q      <= '0;
         ovf_q       <= 1'b0;
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            wr_q[c] <= '0;
            rd_q[c] <= '0;
         end
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         rr_q        <= rr_d;
         cnt_q       <= cnt_d;
         drop_q      <= drop_d;
         ovf_q       <= ovf_d;
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            wr_q[c] <= wr_d[c];
            rd_q[c] <= rd_d[c];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (push[c])
            mem_q[c][wr_q[c][AW-1:0]] <= in_data[c*DATA_W +: DATA_W];
      end
   end

   assign trace_valid = out_valid_q;
   assign trace_data  = out_data_q;
   assign trace_chan  = out_chan_q;
   assign trace_idle  = reset && active && !out_valid_q;
   assign cycle_count = cnt_q;
   assign drop_count  = drop_q;
   assign overflow    = ovf_q;
   assign done        = (state_q == S_DONE) || (state_q == S_TMO);
   assign timeout     = (state_q == S_TMO);

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed bench for cpu_trace_monitor: per-channel scoreboard queues filled at
// drive time and drained when the trace port accepts a word.
module tb_cpu_trace_monitor;

   localparam int unsigned DW  = 64;
   localparam int unsigned CH  = 2;
   localparam int unsigned DEP = 16;

   logic              clk;
   logic              reset;
   logic              halt;
   logic [CH-1:0]     in_valid;
   logic [CH*DW-1:0]  in_data;
   logic              trace_valid;
   logic              trace_ready;
   logic [0:0]        trace_chan;
   logic [DW-1:0]     trace_data;
   logic              trace_idle;
   logic [31:0]       cycle_count;
   logic [15:0]       drop_count;
   logic              overflow;
   logic              done;
   logic              timeout;

   cpu_trace_monitor #(
      .DATA_W   (DW),
      .CHANNELS (CH),
      .DEPTH    (DEP),
      .TIMEOUT  (50)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .halt        (halt),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .trace_valid (trace_valid),
      .trace_ready (trace_ready),
      .trace_chan  (trace_chan),
      .trace_data  (trace_data),
      .trace_idle  (trace_idle),
      .cycle_count (cycle_count),
      .drop_count  (drop_count),
      .overflow    (overflow),
      .done        (done),
      .timeout     (timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          total;
   int          bad;
   int          edges;
   bit          sb_en;
   logic [DW-1:0] q0 [$];
   logic [DW-1:0] q1 [$];
   logic [0:0]    acc_ch [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_pop();
      logic [DW-1:0] exp;
      acc_ch.push_back(trace_chan);
      if (trace_chan == 1'b0) begin
         total++;
         assert (q0.size() > 0) else begin
            bad++;
            $error("FAIL sb_extra_ch0 observed=%0h expected=none", trace_data);
         end
         if (q0.size() > 0) begin
            exp = q0.pop_front();
            chk("sb_ch0", trace_data, exp);
         end
      end else begin
         total++;
         assert (q1.size() > 0) else begin
            bad++;
            $error("FAIL sb_extra_ch1 observed=%0h expected=none", trace_data);
         end
         if (q1.size() > 0) begin
            exp = q1.pop_front();
            chk("sb_ch1", trace_data, exp);
         end
      end
   endtask

   // One clock: the word offered before the edge is scored if accepted.
   task automatic step();
      @(negedge clk);
      if (sb_en && trace_valid === 1'b1 && trace_ready === 1'b1) sb_pop();
      @(posedge clk);
      #1;
      edges++;
   endtask

   task automatic rst();
      in_valid = '0;
      halt     = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("rst_valid", trace_valid, 0);
      chk("rst_chan", trace_chan, 0);
      chk("rst_data", trace_data, 0);
      chk("rst_idle", trace_idle, 0);
      chk("rst_cnt", cycle_count, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_done", done, 0);
      chk("rst_tmo", timeout, 0);
      q0.delete();
      q1.delete();
      acc_ch.delete();
      sb_en = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      edges = 0;
      @(posedge clk);
      #1;
      edges = 1;
      chk("rel_cnt", cycle_count, 1);
   endtask

   task automatic drain(input string tag, input int budget);
      for (int n = 0; n < budget && (q0.size() != 0 || q1.size() != 0); n++) step();
      chk(tag, 64'(q0.size() + q1.size()), 0);
   endtask

   initial begin
      total = 0;
      bad = 0;
      edges = 0;
      sb_en = 1'b1;
      reset = 1'b0;
      halt = 1'b0;
      in_valid = '0;
      in_data = '0;
      trace_ready = 1'b1;

      // single word at edge 5, visible after edge 6
      rst();
      for (int i = 0; i < 3; i++) begin
         chk("t1_idle_pre", trace_idle, 1);
         step();
      end
      in_valid = 2'b01;
      in_data[DW-1:0] = 64'hDEAD_BEEF;
      q0.push_back(64'hDEAD_BEEF);
      step();
      in_valid = '0;
      chk("t1_edge5_valid", trace_valid, 0);
      chk("t1_edge5_idle", trace_idle, 1);
      step();
      chk("t1_edge6_valid", trace_valid, 1);
      chk("t1_edge6_chan", trace_chan, 0);
      chk("t1_edge6_data", trace_data, 64'hDEAD_BEEF);
      chk("t1_edge6_idle", trace_idle, 0);
      step();
      chk("t1_after_idle", trace_idle, 1);
      chk("t1_cnt", cycle_count, 7);
      chk("t1_drop", drop_count, 0);

      // both channels every cycle: strict alternation starting at ch0
      rst();
      trace_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 2'b11;
         in_data[DW-1:0]  = 64'(i);
         in_data[2*DW-1:DW] = 64'(100 + i);
         q0.push_back(64'(i));
         q1.push_back(64'(100 + i));
         step();
      end
      in_valid = '0;
      drain("t2_drained", 40);
      step();
      chk("t2_count", 64'(acc_ch.size()), 16);
      for (int k = 0; k < 16 && k < acc_ch.size(); k++)
         chk("t2_rr_chan", acc_ch[k], 64'(k % 2));
      chk("t2_drop", drop_count, 0);
      chk("t2_ovf", overflow, 0);

      // overflow with trace_ready low: DEPTH buffered + 1 held, 2 dropped
      rst();
      trace_ready = 1'b0;
      for (int i = 0; i < DEP + 3; i++) begin
         in_valid = 2'b01;
         in_data[DW-1:0] = 64'(1000 + i);
         if (i <= DEP) q0.push_back(64'(1000 + i));
         step();
         if (i >= 1) begin
            chk("t3_hold_valid", trace_valid, 1);
            chk("t3_hold_data", trace_data, 1000);
         end
      end
      in_valid = '0;
      chk("t3_drop", drop_count, 2);
      chk("t3_ovf", overflow, 1);

      // full FIFO: pop and push on the same edge is not a drop
      trace_ready = 1'b1;
      in_valid = 2'b01;
      in_data[DW-1:0] = 64'd2000;
      q0.push_back(64'd2000);
      step();
      in_valid = '0;
      chk("t4_drop_same", drop_count, 2);
      drain("t4_drained", 30);
      chk("t4_tmo", timeout, 0);

      // halt drains five buffered words, then DONE with frozen counter
      rst();
      trace_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 2'b01;
         in_data[DW-1:0] = 64'(3000 + i);
         q0.push_back(64'(3000 + i));
         step();
      end
      in_valid = '0;
      halt = 1'b1;
      trace_ready = 1'b1;
      step();
      halt = 1'b0;
      in_valid = 2'b11;
      in_data = {64'h5555, 64'h5555};
      chk("t5_drain_done", done, 0);
      for (int n = 0; n < 20; n++) begin
         step();
         if (q0.size() == 0) begin
            chk("t5_done_edge", done, 1);
            break;
         end
         chk("t5_not_done", done, 0);
      end
      chk("t5_q_empty", 64'(q0.size()), 0);
      chk("t5_cnt", cycle_count, 11);
      for (int n = 0; n < 4; n++) begin
         step();
         chk("t5_cnt_frozen", cycle_count, 11);
         chk("t5_valid", trace_valid, 0);
         chk("t5_done_hold", done, 1);
         chk("t5_tmo", timeout, 0);
      end
      in_valid = '0;

      // watchdog at cycle_count 50 with a stalled word in the output register
      rst();
      sb_en = 1'b0;
      trace_ready = 1'b0;
      in_valid = 2'b10;
      in_data[2*DW-1:DW] = 64'd4000;
      step();
      in_data[2*DW-1:DW] = 64'd4002;
      step();
      in_valid = '0;
      for (int n = 0; n < 60 && timeout !== 1'b1; n++) step();
      chk("t6_edge", 64'(edges), 50);
      chk("t6_cnt", cycle_count, 50);
      chk("t6_tmo", timeout, 1);
      chk("t6_done", done, 1);
      chk("t6_idle", trace_idle, 0);
      trace_ready = 1'b1;
      for (int n = 0; n < 3; n++) begin
         step();
         chk("t6_stall_valid", trace_valid, 1);
         chk("t6_stall_chan", trace_chan, 1);
         chk("t6_stall_data", trace_data, 4000);
         chk("t6_cnt_frozen", cycle_count, 50);
      end

      // asynchronous reset from the TIMEOUT state
      rst();
      chk("t7_run_idle", trace_idle, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
